// File: rtl/spi_miso_readback_4mb_pkg.sv
// Shared constants and types for the 4MB SPI slave read-back path.
// Holds the register address map and the read FSM state encoding.
package spi_miso_readback_4mb_pkg;

   // Register address map, shared with the write-side register file
   localparam logic [15:0] ADDR_FPGA_VER          = 16'h0000;
   localparam logic [15:0] ADDR_FPGA_REV_DATE     = 16'h0001;
   localparam logic [15:0] ADDR_FPGA_DIP_SW       = 16'h0002;
   localparam logic [15:0] ADDR_FPGA_BUTTONS      = 16'h0003;
   localparam logic [15:0] ADDR_FPGA_BUTTONS_LED  = 16'h0004;
   localparam logic [15:0] ADDR_FPGA_DRAPE_SWITCH = 16'h0005;
   localparam logic [15:0] ADDR_FPGA_SPARE0_IO    = 16'h0006;
   localparam logic [15:0] ADDR_FPGA_SPARE1_IO    = 16'h0007;
   localparam logic [15:0] ADDR_ADC_ALERTS        = 16'h0008;
   localparam logic [15:0] ADDR_FAULT_FLAGS       = 16'h0009;
   localparam logic [15:0] ADDR_ABS_ENC_CTRL      = 16'h000A;

   // Read-side FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } rd_state_t;

endpackage

// File: rtl/spi_miso_readback_4mb_sync_edge.sv
// Oversampling synchronizer for a raw SPI pin into clk_100m.
// Produces the synchronized level plus one-cycle rise/fall strobes.
module spi_sync_edge_4mb #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk_100m,
   input  logic rst_n_syn,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   // chain[0] is the raw pin, chain[SYNC_STAGES] the synchronized level
   logic [SYNC_STAGES:0] chain;
   logic                 hist_reg;

   assign chain[0] = din;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
         logic stage_reg;
         // One metastability-hardening flop per stage
         always_ff @(posedge clk_100m or negedge rst_n_syn) begin
            if (!rst_n_syn) stage_reg <= RST_VAL;
            else            stage_reg <= chain[gi];
         end
         assign chain[gi+1] = stage_reg;
      end
   endgenerate

   assign level = chain[SYNC_STAGES];

   // History flop used to detect level changes
   always_ff @(posedge clk_100m or negedge rst_n_syn) begin
      if (!rst_n_syn) hist_reg <= RST_VAL;
      else            hist_reg <= level;
   end

   assign rise = level & ~hist_reg;
   assign fall = ~level & hist_reg;

endmodule

// File: rtl/spi_miso_readback_4mb.sv
// Read/transmit side of the 4MB SPI slave register path.
// On a read request it snapshots one 32-bit register and shifts it out
// MSB-first on MISO in SPI mode 0, with SCLK/CS_N oversampled in clk_100m.
module spi_miso_readback_4mb
   import spi_miso_readback_4mb_pkg::*;
#(
   parameter int                DATA_W      = 32,
   parameter int                SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0] BAD_ADDR_D  = 32'hDEAD_BEEF
) (
   input  logic              clk_100m,
   input  logic              rst_n_syn,
   input  logic              spi_sclk,
   input  logic              spi_cs_n,
   input  logic              rd_req,
   input  logic [15:0]       rd_addr,
   input  logic [DATA_W-1:0] ver_reg,
   input  logic [DATA_W-1:0] rev_data_reg,
   input  logic [DATA_W-1:0] dip_sw_reg,
   input  logic [DATA_W-1:0] buttons_reg,
   input  logic [DATA_W-1:0] buttons_led_reg,
   input  logic [DATA_W-1:0] drape_sensor_reg,
   input  logic [DATA_W-1:0] spare0_io_reg,
   input  logic [DATA_W-1:0] spare1_io_reg,
   input  logic [DATA_W-1:0] adc_alerts_reg,
   input  logic [DATA_W-1:0] fault_flags_reg,
   input  logic [DATA_W-1:0] abs_enc_ctrl_reg,
   output logic              spi_miso,
   output logic              miso_oe,
   output logic              rd_busy,
   output logic              rd_done,
   output logic              rd_err
);

   // Bit count at which the last bit has been sampled by the master
   localparam logic [5:0] LAST_CNT = 6'(DATA_W);

   logic sclk_level, sclk_rise, sclk_fall;
   logic cs_n_level, cs_rise, cs_fall;

   rd_state_t         state_reg, state_next;
   logic [DATA_W-1:0] shift_reg, shift_next;
   logic [5:0]        bit_cnt_reg, bit_cnt_next;
   logic              miso_reg, miso_next;
   logic              oe_reg, oe_next;
   logic              err_reg, err_next;

   logic [DATA_W-1:0] sel_word;
   logic              sel_err;

   spi_sync_edge_4mb #(
      .SYNC_STAGES (SYNC_STAGES),
      .RST_VAL     (1'b0)
   ) u_sync_sclk (
      .clk_100m  (clk_100m),
      .rst_n_syn (rst_n_syn),
      .din       (spi_sclk),
      .level     (sclk_level),
      .rise      (sclk_rise),
      .fall      (sclk_fall)
   );

   // CS_N idles high, so its synchronizer resets to the inactive level
   spi_sync_edge_4mb #(
      .SYNC_STAGES (SYNC_STAGES),
      .RST_VAL     (1'b1)
   ) u_sync_cs_n (
      .clk_100m  (clk_100m),
      .rst_n_syn (rst_n_syn),
      .din       (spi_cs_n),
      .level     (cs_n_level),
      .rise      (cs_rise),
      .fall      (cs_fall)
   );

   // Only the SCLK edges and the CS_N level drive this path
   logic unused_ok;
   assign unused_ok = &{1'b0, sclk_level, cs_rise, cs_fall};

   // Address decode: unmapped addresses return the marker word and flag an error
   always_comb begin
      sel_word = BAD_ADDR_D;
      sel_err  = 1'b1;
      case (rd_addr)
         ADDR_FPGA_VER:          begin sel_word = ver_reg;          sel_err = 1'b0; end
         ADDR_FPGA_REV_DATE:     begin sel_word = rev_data_reg;     sel_err = 1'b0; end
         ADDR_FPGA_DIP_SW:       begin sel_word = dip_sw_reg;       sel_err = 1'b0; end
         ADDR_FPGA_BUTTONS:      begin sel_word = buttons_reg;      sel_err = 1'b0; end
         ADDR_FPGA_BUTTONS_LED:  begin sel_word = buttons_led_reg;  sel_err = 1'b0; end
         ADDR_FPGA_DRAPE_SWITCH: begin sel_word = drape_sensor_reg; sel_err = 1'b0; end
         ADDR_FPGA_SPARE0_IO:    begin sel_word = spare0_io_reg;    sel_err = 1'b0; end
         ADDR_FPGA_SPARE1_IO:    begin sel_word = spare1_io_reg;    sel_err = 1'b0; end
         ADDR_ADC_ALERTS:        begin sel_word = adc_alerts_reg;   sel_err = 1'b0; end
         ADDR_FAULT_FLAGS:       begin sel_word = fault_flags_reg;  sel_err = 1'b0; end
         ADDR_ABS_ENC_CTRL:      begin sel_word = abs_enc_ctrl_reg; sel_err = 1'b0; end
         default: ;
      endcase
   end

   // Next-state and datapath: CS_N deassertion aborts before any SCLK activity
   always_comb begin
      state_next   = state_reg;
      shift_next   = shift_reg;
      bit_cnt_next = bit_cnt_reg;
      miso_next    = miso_reg;
      oe_next      = oe_reg;
      err_next     = err_reg;
      case (state_reg)
         ST_IDLE: begin
            miso_next    = 1'b0;
            oe_next      = 1'b0;
            bit_cnt_next = 6'd0;
            if (rd_req && !cs_n_level) begin
               // Snapshot taken here, so later register changes cannot leak in
               shift_next = sel_word;
               err_next   = sel_err;
               state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (cs_n_level) begin
               state_next = ST_IDLE;
            end else begin
               miso_next  = shift_reg[DATA_W-1];
               oe_next    = 1'b1;
               state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cs_n_level) begin
               miso_next    = 1'b0;
               oe_next      = 1'b0;
               bit_cnt_next = 6'd0;
               state_next   = ST_IDLE;
            end else begin
               if (sclk_rise && (bit_cnt_reg < LAST_CNT)) begin
                  bit_cnt_next = bit_cnt_reg + 6'd1;
               end
               if (sclk_fall && (bit_cnt_reg < LAST_CNT)) begin
                  shift_next = {shift_reg[DATA_W-2:0], 1'b0};
                  miso_next  = shift_reg[DATA_W-2];
               end
               if (bit_cnt_next == LAST_CNT) begin
                  state_next = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            miso_next    = 1'b0;
            oe_next      = 1'b0;
            bit_cnt_next = 6'd0;
            state_next   = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk_100m or negedge rst_n_syn) begin
      if (!rst_n_syn) begin
         state_reg   <= ST_IDLE;
         shift_reg   <= '0;
         bit_cnt_reg <= 6'd0;
         miso_reg    <= 1'b0;
         oe_reg      <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         shift_reg   <= shift_next;
         bit_cnt_reg <= bit_cnt_next;
         miso_reg    <= miso_next;
         oe_reg      <= oe_next;
         err_reg     <= err_next;
      end
   end

   assign spi_miso = miso_reg;
   assign miso_oe  = oe_reg;
   assign rd_busy  = (state_reg != ST_IDLE);
   assign rd_done  = (state_reg == ST_DONE);
   assign rd_err   = (state_reg == ST_DONE) && err_reg;

endmodule

// File: tb/tb_spi_miso_readback_4mb.sv
// Directed bench for the SPI MISO read-back path: normal, unmapped,
// snapshot, abort, collision and mid-transfer reset reads.
module tb_spi_miso_readback_4mb;
   import spi_miso_readback_4mb_pkg::*;

   logic        clk_100m = 1'b0;
   logic        rst_n_syn = 1'b0;
   logic        spi_sclk = 1'b0;
   logic        spi_cs_n = 1'b1;
   logic        rd_req = 1'b0;
   logic [15:0] rd_addr = 16'h0;
   logic [31:0] ver_reg          = 32'h0001_0203;
   logic [31:0] rev_data_reg     = 32'h2024_0612;
   logic [31:0] dip_sw_reg       = 32'h0000_000A;
   logic [31:0] buttons_reg      = 32'h1234_5678;
   logic [31:0] buttons_led_reg  = 32'h0000_0044;
   logic [31:0] drape_sensor_reg = 32'h0000_0055;
   logic [31:0] spare0_io_reg    = 32'h0000_0066;
   logic [31:0] spare1_io_reg    = 32'h0000_0077;
   logic [31:0] adc_alerts_reg   = 32'h0000_0088;
   logic [31:0] fault_flags_reg  = 32'h0000_A5A5;
   logic [31:0] abs_enc_ctrl_reg = 32'h0000_00BB;
   logic        spi_miso, miso_oe, rd_busy, rd_done, rd_err;

   int          n_checks = 0;
   int          n_pass = 0;
   int          done_cnt = 0;
   int          err_cnt = 0;
   int          err_orphan = 0;
   int          done_base, err_base;
   int          bit_idx, late_oe;
   logic [31:0] rx_word;

   spi_miso_readback_4mb dut (
      .clk_100m         (clk_100m),
      .rst_n_syn        (rst_n_syn),
      .spi_sclk         (spi_sclk),
      .spi_cs_n         (spi_cs_n),
      .rd_req           (rd_req),
      .rd_addr          (rd_addr),
      .ver_reg          (ver_reg),
      .rev_data_reg     (rev_data_reg),
      .dip_sw_reg       (dip_sw_reg),
      .buttons_reg      (buttons_reg),
      .buttons_led_reg  (buttons_led_reg),
      .drape_sensor_reg (drape_sensor_reg),
      .spare0_io_reg    (spare0_io_reg),
      .spare1_io_reg    (spare1_io_reg),
      .adc_alerts_reg   (adc_alerts_reg),
      .fault_flags_reg  (fault_flags_reg),
      .abs_enc_ctrl_reg (abs_enc_ctrl_reg),
      .spi_miso         (spi_miso),
      .miso_oe          (miso_oe),
      .rd_busy          (rd_busy),
      .rd_done          (rd_done),
      .rd_err           (rd_err)
   );

   always #5 clk_100m = ~clk_100m;

   // Pulse monitor, sampled away from the active edge
   always @(negedge clk_100m) begin
      if (rd_done) done_cnt++;
      if (rd_err && rd_done) err_cnt++;
      if (rd_err && !rd_done) err_orphan++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   // Assert CS_N and issue a one-cycle read request; returns two clocks after rd_req
   task automatic begin_read(input logic [15:0] addr);
      spi_cs_n = 1'b0;
      repeat (4) @(negedge clk_100m);
      rx_word   = 32'h0;
      bit_idx   = 0;
      late_oe   = 0;
      done_base = done_cnt;
      err_base  = err_cnt;
      rd_addr   = addr;
      rd_req    = 1'b1;
      @(negedge clk_100m);
      rd_req  = 1'b0;
      rd_addr = 16'h0;
      @(negedge clk_100m);
   endtask

   // 10 MHz SCLK, mode 0: master samples MISO as SCLK rises
   task automatic sclk_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_100m);
         if (bit_idx < 32) rx_word = {rx_word[30:0], spi_miso};
         else if (miso_oe) late_oe++;
         bit_idx++;
         spi_sclk = 1'b1;
         repeat (5) @(negedge clk_100m);
         spi_sclk = 1'b0;
         repeat (4) @(negedge clk_100m);
      end
   endtask

   task automatic end_read();
      repeat (4) @(negedge clk_100m);
      spi_cs_n = 1'b1;
      repeat (6) @(negedge clk_100m);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk_100m);
      chk("rst_miso", {31'b0, spi_miso}, 32'd0);
      chk("rst_oe",   {31'b0, miso_oe},  32'd0);
      chk("rst_busy", {31'b0, rd_busy},  32'd0);
      chk("rst_done", {31'b0, rd_done},  32'd0);
      chk("rst_err",  {31'b0, rd_err},   32'd0);
      rst_n_syn = 1'b1;
      repeat (4) @(negedge clk_100m);

      // rd_req with CS_N high is ignored
      rd_addr = ADDR_FPGA_VER; rd_req = 1'b1;
      @(negedge clk_100m);
      rd_req = 1'b0;
      repeat (2) @(negedge clk_100m);
      chk("req_cs_high_busy", {31'b0, rd_busy}, 32'd0);

      // 1. Normal read
      begin_read(ADDR_FPGA_VER);
      chk("t1_oe_at_2clk",   {31'b0, miso_oe}, 32'd1);
      chk("t1_busy",         {31'b0, rd_busy}, 32'd1);
      chk("t1_miso_at_2clk", {31'b0, spi_miso}, 32'd0);
      sclk_pulses(32);
      end_read();
      $display("read ver     rx=%h done=%0d err=%0d", rx_word, done_cnt - done_base, err_cnt - err_base);
      chk("t1_rx",   rx_word, 32'h0001_0203);
      chk("t1_done", 32'(done_cnt - done_base), 32'd1);
      chk("t1_err",  32'(err_cnt - err_base), 32'd0);
      chk("t1_idle_oe", {31'b0, miso_oe}, 32'd0);

      // 2. Unmapped address
      begin_read(16'hFFFF);
      chk("t2_miso_at_2clk", {31'b0, spi_miso}, 32'd1);
      sclk_pulses(32);
      end_read();
      $display("read bad     rx=%h done=%0d err=%0d", rx_word, done_cnt - done_base, err_cnt - err_base);
      chk("t2_rx",   rx_word, 32'hDEAD_BEEF);
      chk("t2_done", 32'(done_cnt - done_base), 32'd1);
      chk("t2_err",  32'(err_cnt - err_base), 32'd1);

      // 3. Snapshot immunity
      begin_read(ADDR_FAULT_FLAGS);
      sclk_pulses(4);
      fault_flags_reg = 32'hFFFF_FFFF;
      sclk_pulses(28);
      end_read();
      $display("read fault   rx=%h done=%0d", rx_word, done_cnt - done_base);
      chk("t3_rx",   rx_word, 32'h0000_A5A5);
      chk("t3_done", 32'(done_cnt - done_base), 32'd1);

      // 4. Abort after 12 SCLKs, then a clean DIP switch read
      begin_read(ADDR_FPGA_SPARE0_IO);
      sclk_pulses(12);
      spi_cs_n = 1'b1;
      repeat (4) @(negedge clk_100m);
      chk("t4_abort_oe",   {31'b0, miso_oe}, 32'd0);
      chk("t4_abort_busy", {31'b0, rd_busy}, 32'd0);
      repeat (20) @(negedge clk_100m);
      $display("read abort   bits=%0d done=%0d", bit_idx, done_cnt - done_base);
      chk("t4_abort_done", 32'(done_cnt - done_base), 32'd0);
      begin_read(ADDR_FPGA_DIP_SW);
      sclk_pulses(32);
      end_read();
      $display("read dip     rx=%h done=%0d", rx_word, done_cnt - done_base);
      chk("t4_rx",   rx_word, 32'h0000_000A);
      chk("t4_done", 32'(done_cnt - done_base), 32'd1);

      // 5. Second rd_req mid-shift is ignored; 40 SCLKs sent
      begin_read(ADDR_FPGA_BUTTONS);
      sclk_pulses(16);
      rd_addr = ADDR_FPGA_VER; rd_req = 1'b1;
      @(negedge clk_100m);
      rd_req = 1'b0; rd_addr = 16'h0;
      chk("t5_busy_mid", {31'b0, rd_busy}, 32'd1);
      sclk_pulses(24);
      end_read();
      $display("read collide rx=%h done=%0d late_oe=%0d", rx_word, done_cnt - done_base, late_oe);
      chk("t5_rx",      rx_word, 32'h1234_5678);
      chk("t5_done",    32'(done_cnt - done_base), 32'd1);
      chk("t5_late_oe", 32'(late_oe), 32'd0);

      // 6. Reset at bit 16, then a clean read
      begin_read(ADDR_FPGA_DIP_SW);
      sclk_pulses(16);
      chk("t6_oe_before", {31'b0, miso_oe}, 32'd1);
      rst_n_syn = 1'b0;
      #1;
      chk("t6_rst_miso", {31'b0, spi_miso}, 32'd0);
      chk("t6_rst_oe",   {31'b0, miso_oe},  32'd0);
      chk("t6_rst_busy", {31'b0, rd_busy},  32'd0);
      spi_cs_n = 1'b1;
      repeat (3) @(negedge clk_100m);
      rst_n_syn = 1'b1;
      repeat (4) @(negedge clk_100m);
      $display("read reset   bits=%0d done=%0d", bit_idx, done_cnt - done_base);
      chk("t6_rst_done", 32'(done_cnt - done_base), 32'd0);
      begin_read(ADDR_FPGA_REV_DATE);
      sclk_pulses(32);
      end_read();
      $display("read rev     rx=%h done=%0d", rx_word, done_cnt - done_base);
      chk("t6_rx",   rx_word, 32'h2024_0612);
      chk("t6_done", 32'(done_cnt - done_base), 32'd1);

      chk("err_without_done", 32'(err_orphan), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Watchdog so the run always ends on its own
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
